// File: rtl/alu_seq_pkg.sv
// Shared definitions for the UART-driven ALU command sequencer.
//   - seq_state_t     : sequencer state encoding
//   - TIMEOUT_CYCLES_DEFAULT : default inter-byte idle limit in clocks
//   - STAT_*_BIT      : bit positions inside the optional status byte
//   - status_byte()   : packs the sign/zero flags into a status byte
// Optional feature macro: ALU_SEQ_STATUS_EN adds the SEND_STAT state.
package alu_seq_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

    localparam int STAT_ZERO_BIT = 0;
    localparam int STAT_NEG_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_B     = 3'd1,
        ST_GET_OP    = 3'd2,
        ST_EXEC      = 3'd3,
        ST_SEND      = 3'd4
`ifdef ALU_SEQ_STATUS_EN
        ,
        ST_SEND_STAT = 3'd5
`endif
    } seq_state_t;

    function automatic logic [7:0] status_byte(input logic neg, input logic zero);
        logic [7:0] s;
        s                = '0;
        s[STAT_NEG_BIT]  = neg;
        s[STAT_ZERO_BIT] = zero;
        return s;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_byte_timer.sv
// byte_timer: idle-clock watchdog between bytes of one command frame.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   clear       : a byte was consumed this cycle; restart the count
//   enable      : the sequencer is waiting for a follow-on byte
//   expired     : high for the cycle in which TIMEOUT_CYCLES idle clocks
//                 have elapsed without a byte (combinational)
module byte_timer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // The count holds the number of idle clocks already spent; the clock
    // that would complete the TIMEOUT_CYCLES-th idle clock is the expiry.
    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects three UART bytes (a, b, opcode), presents
// them to an external combinational ALU, and pushes the result byte back
// to the UART transmit FIFO.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rx_empty, r_data    : receive FIFO status and head byte
//   rd_uart             : one-cycle pop strobe (same cycle the byte is latched)
//   tx_full             : transmit FIFO full
//   wr_uart, w_data     : one-cycle push strobe and registered byte
//   a, b, op            : registered ALU operands / opcode
//   w                   : combinational ALU result
//   busy                : high whenever not IDLE
//   frame_err           : one-cycle pulse on inter-byte timeout
// Optional feature macro: ALU_SEQ_STATUS_EN -- after the result byte a
// status byte {6'b0, negative, zero} is pushed as well.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REG_SIZE       = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_empty,
    input  logic [7:0]                 r_data,
    output logic                       rd_uart,
    input  logic                       tx_full,
    output logic                       wr_uart,
    output logic [7:0]                 w_data,
    output logic signed [REG_SIZE-1:0] a,
    output logic signed [REG_SIZE-1:0] b,
    output logic [REG_SIZE-1:0]        op,
    input  logic signed [REG_SIZE-1:0] w,
    output logic                       busy,
    output logic                       frame_err
);

    function automatic logic signed [REG_SIZE-1:0] byte_to_operand(input logic [7:0] v);
        return REG_SIZE'(signed'(v));
    endfunction

    function automatic logic [REG_SIZE-1:0] byte_to_opcode(input logic [7:0] v);
        return REG_SIZE'(v);
    endfunction

    function automatic logic [7:0] result_to_byte(input logic signed [REG_SIZE-1:0] r);
        return 8'(r);
    endfunction

    seq_state_t state;
    logic       take_byte;
    logic       push_byte;
    logic       waiting;
    logic       timeout;

`ifdef ALU_SEQ_STATUS_EN
    logic signed [REG_SIZE-1:0] result;
`endif

    // The FIFO handshake strobes are decoded from the state register so the
    // pop lands in the same cycle the head byte is latched; a registered
    // strobe would pop one cycle late and re-read the same head byte.
    assign waiting   = (state == ST_GET_B) || (state == ST_GET_OP);
    assign take_byte = !reset && !rx_empty && ((state == ST_IDLE) || waiting);
`ifdef ALU_SEQ_STATUS_EN
    assign push_byte = !reset && !tx_full && ((state == ST_SEND) || (state == ST_SEND_STAT));
`else
    assign push_byte = !reset && !tx_full && (state == ST_SEND);
`endif
    assign rd_uart = take_byte;
    assign wr_uart = push_byte;
    assign busy    = (state != ST_IDLE);

    byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (take_byte),
        .enable (waiting),
        .expired(timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            a         <= '0;
            b         <= '0;
            op        <= '0;
            w_data    <= '0;
            frame_err <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
            result    <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_byte) begin
                        a     <= byte_to_operand(r_data);
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (take_byte) begin
                        b     <= byte_to_operand(r_data);
                        state <= ST_GET_OP;
                    end else if (timeout) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_GET_OP: begin
                    if (take_byte) begin
                        op    <= byte_to_opcode(r_data);
                        state <= ST_EXEC;
                    end else if (timeout) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // w_data doubles as the captured result for the push.
                    w_data <= result_to_byte(w);
`ifdef ALU_SEQ_STATUS_EN
                    result <= w;
`endif
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (push_byte) begin
`ifdef ALU_SEQ_STATUS_EN
                        w_data <= status_byte(result[REG_SIZE-1], result == '0);
                        state  <= ST_SEND_STAT;
`else
                        state  <= ST_IDLE;
`endif
                    end
                end
`ifdef ALU_SEQ_STATUS_EN
                ST_SEND_STAT: begin
                    if (push_byte) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int TO = 16;
`ifdef ALU_SEQ_STATUS_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] a, b, op, w;
    logic       busy, frame_err;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.REG_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .a(a), .b(b), .op(op), .w(w), .busy(busy), .frame_err(frame_err)
    );

    // External ALU stand-in
    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
        case (o)
            8'h20:   return x + y;
            8'h22:   return x - y;
            8'h24:   return x & y;
            8'h25:   return x | y;
            8'h26:   return x ^ y;
            default: return x;
        endcase
    endfunction
    assign w = alu_f(a, b, op);

    // Reference model on plain integers
    function automatic int ref_result(input int x, input int y, input int o);
        int r;
        case (o)
            32:      r = x + y;
            34:      r = x - y;
            36:      r = x & y;
            37:      r = x | y;
            38:      r = x ^ y;
            default: r = x;
        endcase
        return ((r % 256) + 256) % 256;
    endfunction

    function automatic int ref_status(input int r);
        return ((r >= 128) ? 2 : 0) + ((r == 0) ? 1 : 0);
    endfunction

    // Receive FIFO model
    logic [7:0] rx_mem [0:255];
    int rx_head = 0;
    int rx_tail = 0;
    logic pop_pending = 1'b0;
    assign rx_empty = (rx_head == rx_tail);
    assign r_data   = rx_mem[rx_head[7:0]];

    // Monitor: sampled on the falling edge, away from the active edge
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, fe_cnt = 0, fe_cyc = 0;
    int rd_empty_viol = 0, wr_full_viol = 0;
    int rd_cyc [0:1023];
    int wr_cyc [0:1023];
    logic [7:0] tx_log [0:1023];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop_pending) rx_head <= rx_head + 1;
    end

    always @(negedge clk) begin
        pop_pending <= rd_uart;
        if (rd_uart) begin
            rd_cyc[rd_cnt % 1024] <= cyc;
            rd_cnt <= rd_cnt + 1;
            if (rx_empty) rd_empty_viol <= rd_empty_viol + 1;
        end
        if (wr_uart) begin
            wr_cyc[wr_cnt % 1024] <= cyc;
            tx_log[wr_cnt % 1024] <= w_data;
            wr_cnt <= wr_cnt + 1;
            if (tx_full) wr_full_viol <= wr_full_viol + 1;
        end
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        rx_mem[rx_tail[7:0]] = v;
        rx_tail = rx_tail + 1;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic run_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o,
                             input logic [7:0] e, input string nm);
        int wr0, rd0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        push(x); push(y); push(o);
        wait_wr(wr0 + NB, 40);
        repeat (3) step();
        check({nm, " push count"}, wr_cnt - wr0, NB);
        check({nm, " pop count"}, rd_cnt - rd0, 3);
        check({nm, " w_data"}, tx_log[wr0 % 1024], e);
`ifdef ALU_SEQ_STATUS_EN
        check({nm, " status"}, tx_log[(wr0 + 1) % 1024], ref_status(e));
`endif
        check({nm, " latency"}, wr_cyc[wr0 % 1024] - rd_cyc[(rd0 + 2) % 1024], 2);
        check({nm, " a"}, a, x);
        check({nm, " b"}, b, y);
        check({nm, " op"}, op, o);
        check({nm, " busy"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        logic [7:0] ops [6];
        int exp_q [$];
        int wr0, rd0, fe0;
        logic [7:0] op_prev, x, y, o;

        tbl[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        tbl[1] = '{8'hFE, 8'h02, 8'h20, 8'h00};
        tbl[2] = '{8'h10, 8'h20, 8'h22, 8'hF0};
        tbl[3] = '{8'hF0, 8'h0F, 8'h24, 8'h00};
        tbl[4] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        tbl[5] = '{8'h7F, 8'h01, 8'h20, 8'h80};
        tbl[6] = '{8'hAA, 8'hFF, 8'h26, 8'h55};
        tbl[7] = '{8'h12, 8'h34, 8'h99, 8'h12};
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h99};

        // Reset state
        repeat (3) step();
        check("reset a/b/op/w_data", {a, b, op, w_data}, 0);
        check("reset strobes", {busy, rd_uart, wr_uart, frame_err}, 0);
        reset = 1'b0;
        step();

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Back-pressure: tx_full held for 10 cycles
        tx_full = 1'b1;
        wr0 = wr_cnt;
        push(8'hFE); push(8'h02); push(8'h20);
        repeat (10) step();
        check("backpressure no push", wr_cnt - wr0, 0);
        check("backpressure busy", busy, 1);
        tx_full = 1'b0;
        wait_wr(wr0 + NB, 10);
        repeat (2) step();
        check("backpressure push count", wr_cnt - wr0, NB);
        check("backpressure w_data", tx_log[wr0 % 1024], 8'h00);

        // Inter-byte timeout
        op_prev = op;
        fe0 = fe_cnt;
        rd0 = rd_cnt;
        push(8'h11); push(8'h22);
        repeat (TO + 6) step();
        check("timeout frame_err count", fe_cnt - fe0, 1);
        check("timeout frame_err timing", fe_cyc - rd_cyc[(rd0 + 1) % 1024], TO + 1);
        check("timeout busy", busy, 0);
        check("timeout a kept", a, 8'h11);
        check("timeout b kept", b, 8'h22);
        check("timeout op kept", op, op_prev);
        run_frame(8'h05, 8'h07, 8'h20, 8'h0C, "after-timeout");

        // Reset while in GET_OP, with the op byte just arriving
        wr0 = wr_cnt;
        push(8'h33); push(8'h44);
        step(); step();
        push(8'h20);
        reset = 1'b1;
        #1;
        check("rst getop a/b/op/w_data", {a, b, op, w_data}, 0);
        check("rst getop strobes", {busy, rd_uart, wr_uart, frame_err}, 0);
        rx_tail = rx_head;
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        check("rst getop no push", wr_cnt - wr0, 0);

        // Reset while in SEND
        tx_full = 1'b1;
        push(8'h09); push(8'h01); push(8'h20);
        repeat (6) step();
        check("rst send busy before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst send a/b/op/w_data", {a, b, op, w_data}, 0);
        check("rst send strobes", {busy, rd_uart, wr_uart, frame_err}, 0);
        tx_full = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        check("rst send no push", wr_cnt - wr0, 0);

        // Back-to-back: six bytes queued at once
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        push(8'h01); push(8'h02); push(8'h20);
        push(8'h10); push(8'h03); push(8'h22);
        wait_wr(wr0 + 2 * NB, 60);
        repeat (3) step();
        check("b2b pop count", rd_cnt - rd0, 6);
        check("b2b push count", wr_cnt - wr0, 2 * NB);
        check("b2b frame1", tx_log[wr0 % 1024], 8'h03);
        check("b2b frame2", tx_log[(wr0 + NB) % 1024], 8'h0D);

        // Randomized frames with random back-pressure
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        for (int f = 0; f < 30; f++) begin
            int target;
            x = 8'($urandom);
            y = 8'($urandom);
            o = ops[$urandom_range(0, 5)];
            exp_q.push_back(ref_result(int'(x), int'(y), int'(o)));
`ifdef ALU_SEQ_STATUS_EN
            exp_q.push_back(ref_status(ref_result(int'(x), int'(y), int'(o))));
`endif
            push(x); push(y); push(o);
            target = wr_cnt + NB;
            for (int c = 0; c < 200 && wr_cnt < target; c++) begin
                tx_full = ($urandom_range(0, 3) == 0);
                step();
            end
            tx_full = 1'b0;
            repeat (2) step();
        end
        check("random pop count", rd_cnt - rd0, 90);
        check("random push count", wr_cnt - wr0, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("random byte%0d", k), tx_log[(wr0 + k) % 1024], exp_q[k]);
        end

        check("rd_uart while rx_empty", rd_empty_viol, 0);
        check("wr_uart while tx_full", wr_full_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
